// File: rtl/record_core.sv
// Audio capture engine: accepts stereo samples over valid/ready, buffers them in a
// small FIFO and commits one word per SDRAM write request from a chosen start address.
module record_core #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WORDS  = 1048576
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              record_start,
  input  logic [ADDR_W-1:0] record_select,
  input  logic              record_pause,
  input  logic              record_stop,
  output logic              record_done,
  output logic [ADDR_W-1:0] record_length,
  output logic              record_write,
  output logic [ADDR_W-1:0] record_addr,
  output logic [DATA_W-1:0] record_writedata,
  input  logic              record_sdram_finished,
  input  logic              record_audio_valid,
  input  logic [DATA_W-1:0] record_audio_data,
  output logic              record_audio_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ACC_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RECORD, S_PAUSE, S_FLUSH, S_DONE
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [ACC_W-1:0]  accepted_q, accepted_d;
  logic [ADDR_W-1:0] addr_q, length_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q, gap_q, done_q;
  logic              fifo_full, fifo_empty, draining, push, pop;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign draining   = (state_q == S_RECORD) || (state_q == S_PAUSE) || (state_q == S_FLUSH);

  // Ready comes from state only, so there is no path from record_audio_valid.
  assign record_audio_ready = (state_q == S_RECORD) && !fifo_full &&
                              (accepted_q < ACC_W'(MAX_WORDS));
  assign push       = record_audio_valid && record_audio_ready;
  assign pop        = write_q && record_sdram_finished;
  assign accepted_d = accepted_q + ACC_W'(push);

  assign record_done      = done_q;
  assign record_length    = length_q;
  assign record_write     = write_q;
  assign record_addr      = addr_q;
  assign record_writedata = wdata_q;

  // Sample storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= record_audio_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      accepted_q <= '0;
      addr_q     <= '0;
      length_q   <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      gap_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      gap_q  <= 1'b0;

      if (push) begin
        wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
        accepted_q <= accepted_d;
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      // One request in flight; a finished forces a one-cycle idle gap before the next.
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        addr_q   <= addr_q + ADDR_W'(1);
        length_q <= length_q + ADDR_W'(1);
        write_q  <= 1'b0;
        gap_q    <= 1'b1;
      end else if (draining && !write_q && !gap_q && !fifo_empty) begin
        write_q <= 1'b1;
        wdata_q <= mem_q[rd_ptr_q];
      end

      case (state_q)
        S_IDLE: begin
          if (record_start) begin
            state_q    <= S_RECORD;
            addr_q     <= record_select;
            length_q   <= '0;
            accepted_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
          end
        end
        S_RECORD: begin
          if (record_stop || accepted_d == ACC_W'(MAX_WORDS)) state_q <= S_FLUSH;
          else if (record_pause)                               state_q <= S_PAUSE;
        end
        S_PAUSE: begin
          if (record_stop || accepted_d == ACC_W'(MAX_WORDS)) state_q <= S_FLUSH;
          else if (!record_pause)                              state_q <= S_RECORD;
        end
        S_FLUSH: begin
          if (fifo_empty && !write_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_record_core.sv
// Directed bench for record_core: one default instance plus a MAX_WORDS=4 instance
// for the limit/wrap case, each served by a small SDRAM responder that logs writes.
module tb_record_core;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stop = 1'b0, pause = 1'b0, fin = 1'b0, valid = 1'b0;
  logic [AW-1:0] sel = '0;
  logic [DW-1:0] din = '0;
  logic          done, write, ready;
  logic [AW-1:0] len, addr;
  logic [DW-1:0] wdata;

  logic          l_start = 1'b0, l_fin = 1'b0, l_valid = 1'b0;
  logic [AW-1:0] l_sel = '0;
  logic [DW-1:0] l_din = '0;
  logic          l_done, l_write, l_ready;
  logic [AW-1:0] l_len, l_addr;
  logic [DW-1:0] l_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  record_core #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) u_dut (
    .i_clk(clk), .i_rst(rst), .record_start(start), .record_select(sel),
    .record_pause(pause), .record_stop(stop), .record_done(done),
    .record_length(len), .record_write(write), .record_addr(addr),
    .record_writedata(wdata), .record_sdram_finished(fin),
    .record_audio_valid(valid), .record_audio_data(din), .record_audio_ready(ready)
  );

  record_core #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD), .MAX_WORDS(4)) u_lim (
    .i_clk(clk), .i_rst(rst), .record_start(l_start), .record_select(l_sel),
    .record_pause(1'b0), .record_stop(1'b0), .record_done(l_done),
    .record_length(l_len), .record_write(l_write), .record_addr(l_addr),
    .record_writedata(l_wdata), .record_sdram_finished(l_fin),
    .record_audio_valid(l_valid), .record_audio_data(l_din), .record_audio_ready(l_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SDRAM responder for the main instance: finished LAT cycles after the request.
  int            lat = 2;
  bit            hold = 1'b0;
  int            done_cnt = 0;
  logic [AW-1:0] q_addr [$];
  logic [DW-1:0] q_data [$];

  initial begin
    int            cnt;
    bit            busy;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    cnt = 0; busy = 1'b0; a0 = '0; d0 = '0;
    forever begin
      @(negedge clk);
      fin = 1'b0;
      if (done) done_cnt++;
      if (!write) begin
        cnt = 0; busy = 1'b0;
      end else begin
        if (!busy) begin busy = 1'b1; a0 = addr; d0 = wdata; end
        if (!hold) cnt++;
        if (cnt >= lat) begin
          chk("addr_stable", addr, a0);
          chk("data_stable", wdata, d0);
          q_addr.push_back(addr);
          q_data.push_back(wdata);
          fin = 1'b1;
          cnt = 0;
        end
      end
    end
  end

  // Responder for the limit instance: finished one cycle after the request.
  int            l_done_cnt = 0;
  logic [AW-1:0] lq_addr [$];
  logic [DW-1:0] lq_data [$];

  initial forever begin
    @(negedge clk);
    l_fin = 1'b0;
    if (l_done) l_done_cnt++;
    if (l_write) begin
      lq_addr.push_back(l_addr);
      lq_data.push_back(l_wdata);
      l_fin = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic put(input logic [DW-1:0] d);
    int n;
    n = 0;
    valid = 1'b1; din = d;
    while (!ready && n < 100) begin @(negedge clk); n++; end
    if (!ready) chk("put_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [AW-1:0] a);
    sel = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int k);
    int n;
    n = 0;
    while (q_addr.size() < k && n < 400) begin @(negedge clk); n++; end
    chk(tag, q_addr.size(), k);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < 400) begin @(negedge clk); n++; end
    chk(tag, done_cnt - d0, 1);
    @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input int k);
    logic [AW-1:0] ea;
    chk({tag, "_count"}, q_addr.size(), k);
    for (int i = 0; i < k && i < q_addr.size(); i++) begin
      ea = a + AW'(i);
      chk({tag, "_addr"}, q_addr[i], ea);
      chk({tag, "_data"}, q_data[i], d + DW'(i));
    end
    q_addr.delete();
    q_data.delete();
  endtask

  initial begin
    int idx, pc;
    logic [AW-1:0] ea;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_write", write, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_len", len, 0);
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Limit and wrap on the MAX_WORDS=4 instance: automatic done, no stop
    l_sel = 23'h7FFFFE; l_start = 1'b1;
    @(negedge clk);
    l_start = 1'b0;
    l_valid = 1'b1; idx = 0; l_din = 32'hD000_0000;
    repeat (30) begin
      if (l_ready) idx++;
      @(negedge clk);
      l_din = 32'hD000_0000 + DW'(idx);
    end
    l_valid = 1'b0;
    chk("lim_accepts", idx, 4);
    chk("lim_done_cnt", l_done_cnt, 1);
    chk("lim_count", lq_addr.size(), 4);
    for (int i = 0; i < 4 && i < lq_addr.size(); i++) begin
      ea = 23'h7FFFFE + AW'(i);
      chk("lim_addr", lq_addr[i], ea);
      chk("lim_data", lq_data[i], 32'hD000_0000 + DW'(i));
    end
    chk("lim_len", l_len, 4);

    // Basic: 8 samples from 0x100, with 1-cycle accept-to-request latency
    pulse_start(23'h000100);
    put(32'hA000_0000);
    valid = 1'b0;
    chk("lat_accept_edge", write, 0);
    @(negedge clk);
    chk("lat_next_edge", write, 1);
    for (int i = 1; i < 8; i++) put(32'hA000_0000 + DW'(i));
    valid = 1'b0;
    wait_writes("basic_drain", 8);
    pulse_stop();
    chk("done_not_yet", done, 0);
    @(negedge clk);
    chk("done_pulse", done, 1);
    @(negedge clk);
    chk("done_single", done, 0);
    check_writes("basic", 23'h000100, 32'hA000_0000, 8);
    chk("basic_len", len, 8);

    // Backpressure: finished held low, valid constantly high
    hold = 1'b1;
    pulse_start(23'h000010);
    valid = 1'b1; idx = 0; din = 32'hB000_0000;
    repeat (20) begin
      if (ready) idx++;
      @(negedge clk);
      din = 32'hB000_0000 + DW'(idx);
    end
    chk("bp_accepts", idx, FD);
    chk("bp_ready_low", ready, 0);
    chk("bp_write_held", write, 1);
    chk("bp_addr_held", addr, 23'h000010);
    chk("bp_data_held", wdata, 32'hB000_0000);
    hold = 1'b0;
    while (idx < 10) begin put(32'hB000_0000 + DW'(idx)); idx++; end
    valid = 1'b0;
    wait_writes("bp_drain", 10);
    pulse_stop();
    wait_done("bp_done");
    check_writes("bp", 23'h000010, 32'hB000_0000, 10);
    chk("bp_len", len, 10);

    // Pause after 3 samples: no accepts, queue still drains, resume at next address
    pulse_start(23'h000200);
    for (int i = 0; i < 3; i++) put(32'hC000_0000 + DW'(i));
    valid = 1'b0; pause = 1'b1;
    @(negedge clk);
    valid = 1'b1; din = 32'hC000_0003; pc = 0;
    repeat (14) begin
      if (ready) pc++;
      @(negedge clk);
    end
    chk("pause_no_accept", pc, 0);
    chk("pause_drained", q_addr.size(), 3);
    pause = 1'b0;
    for (int i = 3; i < 6; i++) put(32'hC000_0000 + DW'(i));
    valid = 1'b0;
    wait_writes("pause_drain", 6);
    pulse_stop();
    wait_done("pause_done");
    check_writes("pause", 23'h000200, 32'hC000_0000, 6);
    chk("pause_len", len, 6);

    // Edge events: start while recording ignored; stop+pause together flushes
    pulse_start(23'h000300);
    put(32'hE000_0000);
    valid = 1'b0;
    pulse_start(23'h000900);
    put(32'hE000_0001);
    valid = 1'b0;
    stop = 1'b1; pause = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done("stop_pause_done");
    pause = 1'b0;
    check_writes("edge", 23'h000300, 32'hE000_0000, 2);
    idx = done_cnt;
    pulse_stop();
    repeat (6) @(negedge clk);
    chk("idle_stop_no_done", done_cnt - idx, 0);
    chk("idle_len_hold", len, 2);
    chk("idle_ready", ready, 0);

    // Reset while a request is outstanding, then record again from a new select
    hold = 1'b1;
    pulse_start(23'h000400);
    put(32'hF000_0000);
    valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_write", write, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_write", write, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_wdata", wdata, 0);
    chk("mid_rst_len", len, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_done", done, 0);
    rst = 1'b0; hold = 1'b0;
    @(negedge clk);
    q_addr.delete();
    q_data.delete();
    pulse_start(23'h000500);
    put(32'hF000_0001);
    put(32'hF000_0002);
    valid = 1'b0;
    wait_writes("post_rst_drain", 2);
    pulse_stop();
    wait_done("post_rst_done");
    check_writes("post_rst", 23'h000500, 32'hF000_0001, 2);
    chk("post_rst_len", len, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
